sdelay: RTL
===========

SDELAY -- requirements
Module: sdelay

Interface
REQ-001 SHALL have parameter W, default 8: number of serial lanes.
REQ-002 SHALL have parameter D_MAX, default 7: maximum per-lane delay in cycles; legal range 1..63.
REQ-003 SHALL have parameter M, default 4: number of contexts.
REQ-004 SHALL have parameter CFG_W, default 5: config input width.
REQ-005 SHALL have parameter DEFAULT_DELAY, default 0: delay applied to every lane before commit.
REQ-006 SHALL have derived widths: DW = clog2(D_MAX+1); CB = W*DW per delay set; NSET = M if SDELAY_PER_CTX_EN else 1; FRAMES = ceil(NSET*CB/CFG_W).
REQ-007 SHALL have port clk, input, 1 bit: the only clock.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-009 SHALL have port grst, input, 1 bit: S3GA configuration in progress.
REQ-010 SHALL have port m, input, `CNT(M): current context, cycle % M.
REQ-011 SHALL have port cfg, input, 1 bit: config frame valid.
REQ-012 SHALL have port cfg_i, input, CFG_W bits: config frame.
REQ-013 SHALL have port cfgd, output, 1 bit: delays committed.
REQ-014 SHALL have port i, input, W bits: serial lane inputs.
REQ-015 SHALL have port o, output, W bits: delayed serial lane outputs.

Function
REQ-016 SHALL implement a three-state FSM, LOAD -> COMMIT -> DONE; reset enters LOAD.
REQ-017 SHALL, in LOAD, accept a frame only on cycles where cfg=1 and grst=1: the shadow register (FRAMES*CFG_W bits) shifts right by CFG_W, cfg_i enters at the MSB end, and the frame counter increments.
REQ-018 SHALL let cfg=1 with grst=0 have no effect.
REQ-019 SHALL let the counter and shadow hold their values if grst falls mid-load; loading resumes on the next accepted frame.
REQ-020 SHALL, when the FRAMES-th frame is accepted, go to COMMIT on the next cycle, then copy the low NSET*CB shadow bits to the active delay registers and go to DONE.
REQ-021 SHALL set cfgd=1 in DONE only, i.e. the second cycle after the final frame is accepted.
REQ-022 SHALL map bit fields as follows: set s, lane j occupies bits [(s*W+j)*DW +: DW], with the first accepted frame ending at the LSBs.
REQ-023 SHALL ignore cfg in DONE; reconfiguration requires rst.
REQ-024 SHALL keep per-lane history in a D_MAX-bit shift register that shifts i[j] in every cycle while grst=0.
REQ-025 SHALL drive o[j] = i[j] combinationally when the effective delay is 0, and otherwise the history tap: i[j] from d cycles earlier.
REQ-026 SHALL saturate an effective delay greater than D_MAX to D_MAX.
REQ-027 SHALL, while grst=1, force o to 0 and clear all history registers.
REQ-028 SHALL use DEFAULT_DELAY (saturated) for every lane until commit.

Reset
REQ-029 SHALL, on rst, set: FSM to LOAD, frame counter to 0, shadow to 0, active delays to DEFAULT_DELAY, history to 0, cfgd to 0.
REQ-030 SHALL, after rst, drive o to 0 except for delay-0 lanes, which pass i.
REQ-031 SHALL give rst priority over cfg and grst in the same cycle.

Configuration
REQ-032 SHALL, when SDELAY_PER_CTX_EN is defined, hold M delay sets, with lane j's effective delay taken from set m in the current cycle.
REQ-033 SHALL, when SDELAY_PER_CTX_EN is undefined, hold a single set, ignore m, and use FRAMES = ceil(CB/CFG_W).

Structure
REQ-034 SHALL take clog2, `CNT and `V from the shared s3ga.h header; DW, CB and FRAMES are localparams.
REQ-035 SHALL instantiate one sub-module per lane, sdelay_lane: history shift register plus tap mux, with inputs clk, grst, i, d and output o.

Verification (W=4, D_MAX=7, DW=3, CFG_W=5, M=4)
REQ-036 SHALL cover: per-ctx macro off; after rst, pulse i[2]=1 for one cycle with DEFAULT_DELAY=0 -> o[2]=1 the same cycle, and cfgd=0.
REQ-037 SHALL cover: macro off; grst=1, three frames giving lane delays {0,1,3,7} -> cfgd=1 two cycles after the third frame; an impulse on every lane -> o[0..3] rises at +0, +1, +3 and +7 cycles.
REQ-038 SHALL cover: macro off; grst dropped after frame 1 for 5 cycles, then frames 2-3 -> commit is identical to the uninterrupted load, and cfg pulses during the gap are ignored.
REQ-039 SHALL cover: a delay field of 7 with D_MAX=5 (DW=3) -> lane delay is 5.
REQ-040 SHALL cover: macro on, FRAMES=10, sets giving lane 0 delays {1,2,3,4} -> with i[0] held at 1 from cycle t, o[0] tracks the delay of the current m.
REQ-041 SHALL cover: rst asserted in DONE together with cfg=1 -> cfgd=0, delays revert to DEFAULT_DELAY, and the counter is 0.

Source files
------------

// File: rtl/sdelay_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sdelay_pkg
//  Purpose  : Shared types and elaboration-time helpers for the sdelay
//             serial delay block: FSM state encoding, counter width and
//             delay saturation helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package sdelay_pkg;

  // Configuration sequencer states.
  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Width of a counter that holds 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp a requested delay to the largest delay the history can provide.
  function automatic int sat_delay(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdelay_lane.sv
`default_nettype none
// ============================================================================
//  Module   : sdelay_lane
//  Purpose  : One serial lane: a D_MAX-deep history shift register and a tap
//             mux selecting the input from d cycles earlier (d = 0 passes the
//             input straight through).
//  Ports    : clk  - clock
//             grst - clears the history and forces o low while high
//             i    - serial input bit
//             d    - effective delay, already saturated to D_MAX
//             o    - delayed serial output
//  Revision : 1.0 - initial release
// ============================================================================
module sdelay_lane #(
  parameter int D_MAX = 7,
  parameter int DW    = 3
) (
  input  logic          clk,
  input  logic          grst,
  input  logic          i,
  input  logic [DW-1:0] d,
  output logic          o
);

  // hist[k-1] holds the input from k cycles ago.
  logic [D_MAX-1:0] hist;
  logic [D_MAX:0]   hist_ext;
  logic             tap;

  // Concatenate then slice so a single-entry history needs no special case.
  assign hist_ext = {hist, i};

  always_ff @(posedge clk) begin
    if (grst) begin
      hist <= '0;
    end else begin
      hist <= hist_ext[D_MAX-1:0];
    end
  end

  always_comb begin
    tap = i;
    for (int k = 1; k <= D_MAX; k++) begin
      if (d == DW'(k)) begin
        tap = hist[k-1];
      end
    end
    o = grst ? 1'b0 : tap;
  end

endmodule
`default_nettype wire

// File: rtl/sdelay.sv
`default_nettype none
// ============================================================================
//  Module   : sdelay
//  Purpose  : Per-lane programmable serial delay. Delay fields are loaded as
//             CFG_W-bit frames into a shadow register while grst is high,
//             committed to the active delay registers, then applied to each
//             lane's history tap.
//  Macro    : SDELAY_PER_CTX_EN - when defined, M delay sets are held and the
//             set used each cycle is selected by the context input m.
//  Ports    : clk   - clock
//             rst   - synchronous active-high reset
//             grst  - configuration in progress (frames accepted, o forced 0)
//             m     - current context (cycle % M)
//             cfg   - config frame valid
//             cfg_i - config frame
//             cfgd  - delays committed
//             i     - serial lane inputs
//             o     - delayed serial lane outputs
//  Revision : 1.0 - initial release
// ============================================================================
module sdelay
  import sdelay_pkg::*;
#(
  parameter int W             = 8,
  parameter int D_MAX         = 7,
  parameter int M             = 4,
  parameter int CFG_W         = 5,
  parameter int DEFAULT_DELAY = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                grst,
  input  logic [cnt_w(M)-1:0] m,
  input  logic                cfg,
  input  logic [CFG_W-1:0]    cfg_i,
  output logic                cfgd,
  input  logic [W-1:0]        i,
  output logic [W-1:0]        o
);

  localparam int DW = $clog2(D_MAX + 1);
  localparam int CB = W * DW;
`ifdef SDELAY_PER_CTX_EN
  localparam int NSET = M;
`else
  localparam int NSET = 1;
`endif
  localparam int AW     = NSET * CB;
  localparam int FRAMES = (AW + CFG_W - 1) / CFG_W;
  localparam int SHW    = FRAMES * CFG_W;
  localparam int FCW    = $clog2(FRAMES + 1);
  localparam int MW     = cnt_w(M);
  localparam logic [DW-1:0] DEF_D = DW'(sat_delay(DEFAULT_DELAY, D_MAX));

  state_t           state;
  state_t           state_nx;
  logic [FCW-1:0]   cnt;
  logic [SHW-1:0]   shadow;
  logic [AW-1:0]    active;
  logic             accept;
  logic [SHW+CFG_W-1:0] shadow_ext;
  logic             hist_clr;

  assign accept     = (state == ST_LOAD) && cfg && grst;
  // New frame enters at the MSB end; the oldest frame drifts to the LSBs.
  assign shadow_ext = {cfg_i, shadow};
  assign cfgd       = (state == ST_DONE);

  // --------------------------------------------------------------------------
  // Configuration sequencer
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      ST_LOAD: begin
        if (accept && (cnt == FCW'(FRAMES - 1))) begin
          state_nx = ST_COMMIT;
        end
      end
      ST_COMMIT: state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_DONE;
      default:   state_nx = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_LOAD;
      cnt    <= '0;
      shadow <= '0;
      active <= {(NSET * W){DEF_D}};
    end else begin
      state <= state_nx;
      if (accept) begin
        shadow <= shadow_ext[SHW+CFG_W-1:CFG_W];
        cnt    <= cnt + 1'b1;
      end
      if (state == ST_COMMIT) begin
        active <= shadow[AW-1:0];
      end
    end
  end

  // Reset also wipes the lane histories; the lane clear input doubles for it.
  assign hist_clr = grst | rst;

`ifndef SDELAY_PER_CTX_EN
  logic unused_m;
  assign unused_m = ^m;
`endif

  // --------------------------------------------------------------------------
  // Lanes
  // --------------------------------------------------------------------------
  generate
    for (genvar j = 0; j < W; j++) begin : g_lane
      logic [DW-1:0] raw;
      logic [DW-1:0] eff;

`ifdef SDELAY_PER_CTX_EN
      always_comb begin
        raw = '0;
        for (int s = 0; s < NSET; s++) begin
          if (m == MW'(s)) begin
            raw = active[(s*W+j)*DW +: DW];
          end
        end
      end
`else
      assign raw = active[j*DW +: DW];
`endif

      // A field can only exceed D_MAX when D_MAX+1 is not a power of two.
      if (((1 << DW) - 1) > D_MAX) begin : g_sat
        assign eff = (raw > DW'(D_MAX)) ? DW'(D_MAX) : raw;
      end else begin : g_nosat
        assign eff = raw;
      end

      sdelay_lane #(
        .D_MAX (D_MAX),
        .DW    (DW)
      ) u_lane (
        .clk  (clk),
        .grst (hist_clr),
        .i    (i[j]),
        .d    (eff),
        .o    (o[j])
      );
    end
  endgenerate

endmodule
`default_nettype wire
